// File: rtl/e_gpu_conf_regs.sv
// rtl/e_gpu_conf_regs.sv - OBI-slave configuration registers for the e_gpu controller
module e_gpu_conf_regs #(
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter logic [31:0] DEFAULT_ARGS_ADDR = 32'h0001_0000,
  parameter logic [31:0] DEFAULT_DATA_ADDR = 32'h0001_8000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // OBI request channel
  input  logic                  conf_regs_req_req,
  input  logic                  conf_regs_req_we,
  input  logic [3:0]            conf_regs_req_be,
  input  logic [ADDR_WIDTH-1:0] conf_regs_req_addr,
  input  logic [31:0]           conf_regs_req_wdata,
  output logic                  conf_regs_req_gnt,
  // OBI response channel
  output logic                  conf_regs_rsp_rvalid,
  output logic [31:0]           conf_regs_rsp_rdata,
  // controller side
  input  logic                  cu_end_i,
  output logic                  gpu_en_o,
  output logic                  start_o,
  output logic [31:0]           kernel_args_addr_o,
  output logic [31:0]           kernel_data_addr_o,
  output logic                  irq_o
);

  // word index of each register (address bits [5:2])
  localparam logic [3:0] IDX_CTRL   = 4'd0;
  localparam logic [3:0] IDX_START  = 4'd1;
  localparam logic [3:0] IDX_STATUS = 4'd2;
  localparam logic [3:0] IDX_ARGS   = 4'd3;
  localparam logic [3:0] IDX_DATA   = 4'd4;
  localparam logic [3:0] IDX_CYCLES = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        en_q, irq_en_q;
  logic        en_next, irq_en_next;
  logic        done_q;
  logic        start_q;
  logic [31:0] args_q, data_q;
  logic [31:0] cycles_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [3:0]  word_idx;
  logic        wr_access, rd_access;
  logic        wr_ctrl, wr_start, wr_status, wr_args, wr_data;
  logic        start_req, done_clr;
  logic        launch, cyc_run, finish, busy;
  logic [31:0] rd_mux;

  // only address bits [5:2] select a register; the rest are don't-care
  logic        addr_unused;
  assign addr_unused = ^{conf_regs_req_addr[ADDR_WIDTH-1:6], conf_regs_req_addr[1:0]};

  // merge write data into an old value, byte lane k only when be[k] is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wd[8*k +: 8];
    end
    return res;
  endfunction

  // every request is accepted in the cycle it is presented
  assign conf_regs_req_gnt = conf_regs_req_req;

  assign word_idx  = conf_regs_req_addr[5:2];
  assign wr_access = conf_regs_req_req &  conf_regs_req_we;
  assign rd_access = conf_regs_req_req & ~conf_regs_req_we;

  // write decode strobes
  always_comb begin
    wr_ctrl   = wr_access & (word_idx == IDX_CTRL);
    wr_start  = wr_access & (word_idx == IDX_START);
    wr_status = wr_access & (word_idx == IDX_STATUS);
    wr_args   = wr_access & (word_idx == IDX_ARGS);
    wr_data   = wr_access & (word_idx == IDX_DATA);
    start_req = wr_start  & conf_regs_req_be[0] & conf_regs_req_wdata[0];
    done_clr  = wr_status & conf_regs_req_be[0] & conf_regs_req_wdata[1];
  end

  // CTRL value as it will be after this edge; lets an EN clear stop a run immediately
  always_comb begin
    en_next     = en_q;
    irq_en_next = irq_en_q;
    if (wr_ctrl && conf_regs_req_be[0]) begin
      en_next     = conf_regs_req_wdata[0];
      irq_en_next = conf_regs_req_wdata[1];
    end
  end

  // kernel state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // kernel next-state: EN clear beats cu_end while running, START ignored while running
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req && en_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_next)      state_d = ST_IDLE;
        else if (cu_end_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start_req && en_q) state_d = ST_RUN;
        else if (done_clr)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // kernel control strobes derived from the current and next state
  always_comb begin
    busy    = (state_q == ST_RUN);
    launch  = (state_q != ST_RUN) && (state_d == ST_RUN);
    cyc_run = (state_q == ST_RUN) && (state_d == ST_RUN);
    finish  = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  // CTRL register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      en_q     <= en_next;
      irq_en_q <= irq_en_next;
    end
  end

  // kernel base address registers with byte enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      args_q <= DEFAULT_ARGS_ADDR;
      data_q <= DEFAULT_DATA_ADDR;
    end else begin
      if (wr_args) args_q <= be_merge(args_q, conf_regs_req_wdata, conf_regs_req_be);
      if (wr_data) data_q <= be_merge(data_q, conf_regs_req_wdata, conf_regs_req_be);
    end
  end

  // sticky DONE: a completion in the same cycle as a W1C keeps it set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       done_q <= 1'b0;
    else if (finish)   done_q <= 1'b1;
    else if (done_clr) done_q <= 1'b0;
  end

  // one-cycle start pulse in the cycle after the accepted START write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_q <= 1'b0;
    else         start_q <= launch;
  end

  // execution cycle counter: cleared on launch, saturating count while running
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                cycles_q <= 32'h0;
    else if (launch)                            cycles_q <= 32'h0;
    else if (cyc_run && cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'h1;
  end

  // read data mux; unmapped and write-only offsets read as zero
  always_comb begin
    rd_mux = 32'h0;
    case (word_idx)
      IDX_CTRL:   rd_mux = {30'h0, irq_en_q, en_q};
      IDX_STATUS: rd_mux = {30'h0, done_q, busy};
      IDX_ARGS:   rd_mux = args_q;
      IDX_DATA:   rd_mux = data_q;
      IDX_CYCLES: rd_mux = cycles_q;
      default:    rd_mux = 32'h0;
    endcase
  end

  // response channel: one rvalid per grant, one cycle later; writes return zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= conf_regs_req_req;
      rdata_q  <= rd_access ? rd_mux : 32'h0;
    end
  end

  assign conf_regs_rsp_rvalid = rvalid_q;
  assign conf_regs_rsp_rdata  = rdata_q;
  assign gpu_en_o             = en_q;
  assign start_o              = start_q;
  assign kernel_args_addr_o   = args_q;
  assign kernel_data_addr_o   = data_q;
  assign irq_o                = done_q & irq_en_q;

endmodule

// File: tb/tb_e_gpu_conf_regs.sv
// tb/tb_e_gpu_conf_regs.sv - directed vector bench for e_gpu_conf_regs
module tb_e_gpu_conf_regs;

  logic        clk;
  logic        rst_ni;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        cu_end;
  logic        gpu_en, start, irq;
  logic [31:0] args_addr, data_addr;

  int vectors    = 0;
  int miscompares = 0;

  e_gpu_conf_regs #(
    .ADDR_WIDTH(32),
    .DEFAULT_ARGS_ADDR(32'h0001_0000),
    .DEFAULT_DATA_ADDR(32'h0001_8000)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .conf_regs_req_req   (req),
    .conf_regs_req_we    (we),
    .conf_regs_req_be    (be),
    .conf_regs_req_addr  (addr),
    .conf_regs_req_wdata (wdata),
    .conf_regs_req_gnt   (gnt),
    .conf_regs_rsp_rvalid(rvalid),
    .conf_regs_rsp_rdata (rdata),
    .cu_end_i            (cu_end),
    .gpu_en_o            (gpu_en),
    .start_o             (start),
    .kernel_args_addr_o  (args_addr),
    .kernel_data_addr_o  (data_addr),
    .irq_o               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_start;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; presents one request, returns at the next negedge
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic rv);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    rd = rdata; rv = rvalid;
    req = 1'b0; we = 1'b0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic rv;
    access(1'b1, a, 4'hF, d, rd, rv);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic rv;
    access(1'b0, a, 4'hF, 32'h0, rd, rv);
    check({name, " rdata"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rv;

    vecs[0]  = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'h0001_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h0001_8000, 1'b0};
    vecs[2]  = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h08, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h14, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b1, 32'h04, 4'hF, 32'h1,         32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h08, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0C, 4'h3, 32'hAABB_CCDD, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'h0001_CCDD, 1'b0};
    vecs[9]  = '{1'b1, 32'h10, 4'hC, 32'h1234_5678, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h1234_8000, 1'b0};
    vecs[11] = '{1'b1, 32'h00, 4'h1, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h3,         1'b0};
    vecs[13] = '{1'b1, 32'h00, 4'h1, 32'h0,         32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'h3C, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[15] = '{1'b1, 32'h3C, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h04, 4'hF, 32'h0,         32'h0,         1'b0};

    rst_ni = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; cu_end = 1'b0;
    #12;
    check("reset gpu_en", {31'h0, gpu_en}, 32'h0);
    check("reset start", {31'h0, start}, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset rvalid", {31'h0, rvalid}, 32'h0);
    check("reset args", args_addr, 32'h0001_0000);
    check("reset data", data_addr, 32'h0001_8000);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // register map vectors
    for (int i = 0; i < 17; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, rv);
      check($sformatf("vec%0d rvalid", i), {31'h0, rv}, 32'h1);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d start", i), {31'h0, start}, {31'h0, vecs[i].exp_start});
    end
    check("args out after be write", args_addr, 32'h0001_CCDD);

    // basic kernel run, IRQ disabled
    wr(32'h00, 32'h1);
    check("gpu_en set", {31'h0, gpu_en}, 32'h1);
    wr(32'h04, 32'h1);
    check("start pulse", {31'h0, start}, 32'h1);
    rd_check("status running", 32'h08, 32'h1);
    check("start single cycle", {31'h0, start}, 32'h0);
    repeat (19) @(negedge clk);
    cu_end = 1'b1;
    @(negedge clk);
    cu_end = 1'b0;
    rd_check("status done", 32'h08, 32'h2);
    rd_check("cycles 20", 32'h14, 32'd20);
    check("irq disabled", {31'h0, irq}, 32'h0);

    // run with IRQ enabled
    wr(32'h08, 32'h2);
    rd_check("status cleared", 32'h08, 32'h0);
    wr(32'h00, 32'h3);
    wr(32'h04, 32'h1);
    rd_check("status run2", 32'h08, 32'h1);
    check("irq while running", {31'h0, irq}, 32'h0);
    repeat (5) @(negedge clk);
    cu_end = 1'b1;
    @(negedge clk);
    cu_end = 1'b0;
    check("irq raised", {31'h0, irq}, 32'h1);
    rd_check("cycles 6", 32'h14, 32'd6);

    // restart from DONE keeps DONE; START in RUN ignored; W1C vs cu_end
    wr(32'h04, 32'h1);
    check("restart pulse", {31'h0, start}, 32'h1);
    rd_check("status busy+done", 32'h08, 32'h3);
    wr(32'h04, 32'h1);
    check("start in run ignored", {31'h0, start}, 32'h0);
    cu_end = 1'b1;
    wr(32'h08, 32'h2);
    cu_end = 1'b0;
    rd_check("set beats w1c", 32'h08, 32'h2);
    wr(32'h08, 32'h2);
    rd_check("status idle", 32'h08, 32'h0);
    check("irq cleared", {31'h0, irq}, 32'h0);

    // clearing EN mid-run
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h1);
    repeat (3) @(negedge clk);
    wr(32'h00, 32'h0);
    rd_check("en clear status", 32'h08, 32'h0);
    rd_check("en clear cycles", 32'h14, 32'd3);
    cu_end = 1'b1;
    @(negedge clk);
    cu_end = 1'b0;
    rd_check("cu_end idle ignored", 32'h08, 32'h0);

    // asynchronous reset mid-run with a pending response
    wr(32'h0C, 32'hDEAD_BEEF);
    check("args written", args_addr, 32'hDEAD_BEEF);
    wr(32'h00, 32'h3);
    wr(32'h04, 32'h1);
    req = 1'b1; we = 1'b0; addr = 32'h0C; be = 4'hF;
    @(posedge clk);
    #1;
    check("pending rvalid", {31'h0, rvalid}, 32'h1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async gpu_en", {31'h0, gpu_en}, 32'h0);
    check("async rvalid", {31'h0, rvalid}, 32'h0);
    check("async rdata", rdata, 32'h0);
    check("async args", args_addr, 32'h0001_0000);
    check("async data", data_addr, 32'h0001_8000);
    check("async irq", {31'h0, irq}, 32'h0);
    check("async start", {31'h0, start}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    rst_ni = 1'b1;
    rd_check("post reset ctrl", 32'h00, 32'h0);
    rd_check("post reset status", 32'h08, 32'h0);
    rd_check("post reset cycles", 32'h14, 32'h0);

    // back-to-back write then read of KERNEL_DATA
    req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'hCAFE_F00D;
    #1;
    check("gnt follows req", {31'h0, gnt}, 32'h1);
    @(negedge clk);
    check("b2b wr rvalid", {31'h0, rvalid}, 32'h1);
    check("b2b wr rdata", rdata, 32'h0);
    we = 1'b0; wdata = 32'h0;
    @(negedge clk);
    check("b2b rd rvalid", {31'h0, rvalid}, 32'h1);
    check("b2b rd rdata", rdata, 32'hCAFE_F00D);
    req = 1'b0;
    #1;
    check("gnt low", {31'h0, gnt}, 32'h0);
    @(negedge clk);
    check("b2b rvalid drops", {31'h0, rvalid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
